// File: rtl/booth_pp_gen_16.sv
// Two-stage radix-4 Booth partial-product generator for a 16x16 signed multiply.
// Stage 1 registers the operands; stage 2 registers eight 32-bit rows plus negation bits.
module booth_pp_gen_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] xin0,
   output logic [31:0] xin1,
   output logic [31:0] xin2,
   output logic [31:0] xin3,
   output logic [31:0] xin4,
   output logic [31:0] xin5,
   output logic [31:0] xin6,
   output logic [31:0] xin7,
   output logic [5:0]  cin,
   output logic [1:0]  tail_neg
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // Producers hold data stable while valid && !ready; ready never depends on valid.
   logic        s1_valid_q, s1_valid_d;
   logic [15:0] x_q, y_q;
   logic        out_valid_q, out_valid_d;
   logic [31:0] row_q [8];
   logic [31:0] row_d [8];
   logic [7:0]  neg_q, neg_d;

   logic s2_adv, in_fire, s1_fire;

   assign s2_adv   = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;
   assign in_fire  = in_valid && in_ready;
   assign s1_fire  = s1_valid_q && s2_adv;

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_fire)
         s1_valid_d = 1'b1;
      else if (s1_fire)
         s1_valid_d = 1'b0;
      out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
   end

   // Booth recoding: y is extended with an implicit y[-1]=0 below bit 0.
   always_comb begin
      logic [16:0] y_ext;
      logic [31:0] sx;
      logic [31:0] mag;
      logic [31:0] shifted;
      logic [2:0]  trip;
      logic        neg;
      y_ext = {y_q, 1'b0};
      sx    = {{16{x_q[15]}}, x_q};
      neg_d = '0;
      for (int i = 0; i < 8; i++) begin
         trip = y_ext[2*i +: 3];
         mag  = '0;
         neg  = 1'b0;
         case (trip)
            3'b001, 3'b010: mag = sx;
            3'b011:         mag = sx << 1;
            3'b100: begin
               mag = sx << 1;
               neg = 1'b1;
            end
            3'b101, 3'b110: begin
               mag = sx;
               neg = 1'b1;
            end
            default: mag = '0;
         endcase
         shifted   = mag << (2*i);
         // Negative rows are one's complement; the +1 goes in as a column-0 carry.
         row_d[i]  = neg ? ~shifted : shifted;
         neg_d[i]  = neg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         neg_q       <= '0;
         for (int i = 0; i < 8; i++)
            row_q[i] <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         if (in_fire) begin
            x_q <= x;
            y_q <= y;
         end
         if (s1_fire) begin
            neg_q <= neg_d;
            for (int i = 0; i < 8; i++)
               row_q[i] <= row_d[i];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign xin0      = row_q[0];
   assign xin1      = row_q[1];
   assign xin2      = row_q[2];
   assign xin3      = row_q[3];
   assign xin4      = row_q[4];
   assign xin5      = row_q[5];
   assign xin6      = row_q[6];
   assign xin7      = row_q[7];
   assign cin       = neg_q[5:0];
   assign tail_neg  = neg_q[7:6];

endmodule

// File: tb/tb_booth_pp_gen_16.sv
// Self-checking bench for booth_pp_gen_16: directed cases, back-pressure, reset, and
// randomized traffic scored against an arithmetic Booth model and the x*y invariant.
module tb_booth_pp_gen_16;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] xin0, xin1, xin2, xin3, xin4, xin5, xin6, xin7;
   logic [5:0]  cin;
   logic [1:0]  tail_neg;

   booth_pp_gen_16 dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .out_valid(out_valid), .out_ready(out_ready),
      .xin0(xin0), .xin1(xin1), .xin2(xin2), .xin3(xin3),
      .xin4(xin4), .xin5(xin5), .xin6(xin6), .xin7(xin7),
      .cin(cin), .tail_neg(tail_neg)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];   // accepted {x, y} pairs in order

   task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {xin7..xin0, neg7..neg0}
   function automatic logic [263:0] observed();
      return {xin7, xin6, xin5, xin4, xin3, xin2, xin1, xin0, tail_neg, cin};
   endfunction

   // Booth digits from d_i = -2*y[2i+1] + y[2i] + y[2i-1]; rows from signed arithmetic.
   function automatic logic [263:0] ref_rows(input logic [15:0] a, input logic [15:0] b);
      logic [263:0] r;
      logic [16:0]  be;
      logic [63:0]  t;
      logic [31:0]  v;
      longint       m;
      int           d, hi, mid, lo;
      r  = '0;
      be = {b, 1'b0};
      for (int i = 0; i < 8; i++) begin
         hi  = int'(be[2*i+2]);
         mid = int'(be[2*i+1]);
         lo  = int'(be[2*i]);
         d   = mid + lo - 2*hi;
         m   = longint'($signed(a)) * longint'((d < 0) ? -d : d);
         t   = 64'(m) << (2*i);
         v   = t[31:0];
         r[8 + 32*i +: 32] = (d < 0) ? ~v : v;
         r[i] = (d < 0);
      end
      return r;
   endfunction

   function automatic logic [31:0] row_sum(input logic [263:0] p);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 8; i++)
         s = s + p[8 + 32*i +: 32] + 32'(p[i]);
      return s;
   endfunction

   function automatic logic [31:0] product(input logic [15:0] a, input logic [15:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[31:0];
   endfunction

   // driver + scoreboard: drive at negedge, sample 1ns later (well before posedge)
   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ordy);
      logic [31:0]  e;
      logic [263:0] obs;
      @(negedge clk);
      in_valid  = v;
      x         = a;
      y         = b;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         obs = observed();
         if (exp_q.size() == 0) begin
            check("unexpected_output", 264'(1), 264'(0));
         end else begin
            e = exp_q.pop_front();
            check("rows", obs, ref_rows(e[31:16], e[15:0]));
            check("sum", 264'(row_sum(obs)), 264'(product(e[31:16], e[15:0])));
         end
      end
      if (v && in_ready)
         exp_q.push_back({a, b});
   endtask

   initial begin
      int sent, cycles;
      logic [15:0] pa, pb;
      logic        have;

      // reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", 264'(out_valid), 264'(0));
      check("reset_in_ready", 264'(in_ready), 264'(1));
      check("reset_outputs", observed(), 264'(0));

      // x=3, y=5 with latency check
      step(1'b1, 16'd3, 16'd5, 1'b1);
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("lat_n1_out_valid", 264'(out_valid), 264'(0));
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("lat_n2_out_valid", 264'(out_valid), 264'(1));
      check("x3y5_rows", observed(), {192'h0, 32'h0000000C, 32'h00000003, 8'h00});

      // x=1, y=-1
      step(1'b1, 16'd1, 16'hFFFF, 1'b1);
      step(1'b0, 16'd0, 16'd0, 1'b1);
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("x1ym1_rows", observed(), {224'h0, 32'hFFFFFFFE, 8'h01});

      // x=y=0x8000: only d7=-2
      step(1'b1, 16'h8000, 16'h8000, 1'b1);
      step(1'b0, 16'd0, 16'd0, 1'b1);
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("min_min_rows", observed(), {32'h3FFFFFFF, 224'h0, 8'h80});

      // back-pressure: two accepted, third stalls, then drain in order
      step(1'b1, 16'h1234, 16'h5678, 1'b0);
      check("bp_ready1", 264'(in_ready), 264'(1));
      step(1'b1, 16'hFEDC, 16'h0123, 1'b0);
      check("bp_ready2", 264'(in_ready), 264'(1));
      step(1'b1, 16'h7FFF, 16'h8001, 1'b0);
      check("bp_full_ready", 264'(in_ready), 264'(0));
      step(1'b1, 16'h7FFF, 16'h8001, 1'b0);
      check("bp_full_valid", 264'(out_valid), 264'(1));
      step(1'b1, 16'h7FFF, 16'h8001, 1'b1);
      check("bp_release_ready", 264'(in_ready), 264'(1));
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("bp_drain2_valid", 264'(out_valid), 264'(1));
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("bp_drain3_valid", 264'(out_valid), 264'(1));
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("bp_empty_valid", 264'(out_valid), 264'(0));
      check("bp_queue_empty", 264'(exp_q.size()), 264'(0));

      // reset with both stages full
      step(1'b1, 16'h0F0F, 16'hA5A5, 1'b0);
      step(1'b1, 16'hC3C3, 16'h3C3C, 1'b0);
      step(1'b1, 16'h1111, 16'h2222, 1'b0);
      check("full_before_reset", 264'(in_ready), 264'(0));
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      exp_q.delete();
      check("midrst_out_valid", 264'(out_valid), 264'(0));
      check("midrst_in_ready", 264'(in_ready), 264'(1));
      check("midrst_outputs", observed(), 264'(0));
      step(1'b1, 16'd3, 16'd5, 1'b1);
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("midrst_lat1", 264'(out_valid), 264'(0));
      step(1'b0, 16'd0, 16'd0, 1'b1);
      check("midrst_lat2", 264'(out_valid), 264'(1));

      // randomized traffic with random back-pressure; upstream holds pair until taken
      sent   = 0;
      cycles = 0;
      have   = 1'b0;
      pa     = '0;
      pb     = '0;
      while (sent < 10000 && cycles < 60000) begin
         logic v, r;
         if (!have) begin
            case ($urandom_range(0, 7))
               0:       pa = 16'h8000;
               1:       pa = 16'h7FFF;
               2:       pa = 16'hFFFF;
               default: pa = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
               0:       pb = 16'h8000;
               1:       pb = 16'h7FFF;
               2:       pb = 16'h0000;
               default: pb = 16'($urandom);
            endcase
            have = 1'b1;
         end
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 9) < 7);
         step(v, pa, pb, r);
         if (v && in_ready) begin
            sent++;
            have = 1'b0;
         end
         cycles++;
      end
      check("rand_all_sent", 264'(sent), 264'(10000));
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 100) begin
         step(1'b0, 16'd0, 16'd0, 1'b1);
         cycles++;
      end
      check("rand_drained", 264'(exp_q.size()), 264'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
